// File: rtl/spi_rom_loader.sv
// SPI slave for the MiST ARM file-transfer channel: oversamples the SPI pins in the clk
// domain, decodes the file commands and emits a byte-wide ioctl write stream.
module spi_rom_loader #(
   parameter int            AW         = 22,
   parameter logic [AW-1:0] START_ADDR = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          SPI_SCK,
   input  logic          SPI_SS2,
   input  logic          SPI_DI,
   output logic          downloading,
   output logic [4:0]    index,
   output logic [AW-1:0] ioctl_addr,
   output logic [7:0]    ioctl_data,
   output logic          ioctl_wr
);

   localparam logic [7:0] CMD_FILE_INDEX  = 8'h53;
   localparam logic [7:0] CMD_FILE_TX     = 8'h54;
   localparam logic [7:0] CMD_FILE_TX_DAT = 8'h55;

   logic       sck_p0, sck_p1, sck_prev;
   logic       ss_p0, ss_p1;
   logic       di_p0, di_p1;
   logic       sck_rise;
   logic [2:0] bit_cnt;
   logic [6:0] shreg;
   logic       data_phase;
   logic       vld_p2;
   logic       is_cmd_p2;
   logic [7:0] byte_p2;
   logic [7:0] cmd;

   assign sck_rise = sck_p1 & ~sck_prev;

   // Stage p0/p1: pin synchronizers; byte assembly on synced SCK rising edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_p0     <= 1'b0;
         sck_p1     <= 1'b0;
         sck_prev   <= 1'b0;
         ss_p0      <= 1'b1;
         ss_p1      <= 1'b1;
         di_p0      <= 1'b0;
         di_p1      <= 1'b0;
         bit_cnt    <= 3'd0;
         shreg      <= 7'd0;
         data_phase <= 1'b0;
         vld_p2     <= 1'b0;
         is_cmd_p2  <= 1'b0;
         byte_p2    <= 8'd0;
      end else begin
         sck_p0   <= SPI_SCK;
         sck_p1   <= sck_p0;
         sck_prev <= sck_p1;
         ss_p0    <= SPI_SS2;
         ss_p1    <= ss_p0;
         di_p0    <= SPI_DI;
         di_p1    <= di_p0;
         vld_p2   <= 1'b0;
         if (ss_p1) begin
            // Deselect drops any partial byte; the next byte opens a new command
            bit_cnt    <= 3'd0;
            data_phase <= 1'b0;
         end else if (sck_rise) begin
            shreg   <= {shreg[5:0], di_p1};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               vld_p2     <= 1'b1;
               byte_p2    <= {shreg, di_p1};
               is_cmd_p2  <= ~data_phase;
               data_phase <= 1'b1;
            end
         end
      end
   end

   // Stage p3: command decode and registered ioctl outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cmd         <= 8'd0;
         downloading <= 1'b0;
         index       <= 5'd0;
         ioctl_addr  <= START_ADDR;
         ioctl_data  <= 8'd0;
         ioctl_wr    <= 1'b0;
      end else begin
         ioctl_wr <= 1'b0;
         // Address advances the cycle after each strobe, wrapping at 2^AW
         if (ioctl_wr)
            ioctl_addr <= ioctl_addr + AW'(1);
         if (vld_p2) begin
            if (is_cmd_p2) begin
               cmd <= byte_p2;
            end else begin
               case (cmd)
                  CMD_FILE_INDEX: index <= byte_p2[4:0];
                  CMD_FILE_TX: begin
                     if (byte_p2 != 8'd0) begin
                        downloading <= 1'b1;
                        ioctl_addr  <= START_ADDR;
                     end else begin
                        downloading <= 1'b0;
                     end
                  end
                  CMD_FILE_TX_DAT: begin
                     if (downloading) begin
                        ioctl_data <= byte_p2;
                        ioctl_wr   <= 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_rom_loader.sv
// Bench for spi_rom_loader (AW=4): table of SPI transactions plus hand sequences for
// framing abort, address wrap and reset mid-stream; strobes checked against a scoreboard.
module tb_spi_rom_loader;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          SPI_SCK, SPI_SS2, SPI_DI;
   logic          downloading;
   logic [4:0]    index;
   logic [AW-1:0] ioctl_addr;
   logic [7:0]    ioctl_data;
   logic          ioctl_wr;

   spi_rom_loader #(.AW(AW), .START_ADDR('0)) dut (
      .clk(clk), .rst(rst), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
      .downloading(downloading), .index(index), .ioctl_addr(ioctl_addr),
      .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int half   = 3;

   // Independent model of the host-visible state
   logic          m_dl;
   logic [4:0]    m_idx;
   logic [AW-1:0] m_addr;
   logic [AW+7:0] sb[$];
   logic          prev_wr = 1'b0;

   typedef struct {
      logic [7:0] cmd;
      int         n;
      logic [7:0] b [4];
      logic       exp_dl;
      logic [4:0] exp_idx;
      logic [3:0] exp_addr;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic spi_bit(input logic b);
      SPI_DI = b;
      tick(half);
      SPI_SCK = 1'b1;
      tick(half);
      SPI_SCK = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) spi_bit(b[i]);
      tick(2);
   endtask

   task automatic send_nibble(input logic [3:0] b);
      for (int i = 3; i >= 0; i--) spi_bit(b[i]);
   endtask

   task automatic ss_low();
      SPI_SS2 = 1'b0;
      tick(4);
   endtask

   task automatic ss_high();
      tick(4);
      SPI_SS2 = 1'b1;
      tick(10);
   endtask

   task automatic model_byte(input logic [7:0] c, input logic [7:0] b);
      case (c)
         8'h53: m_idx = b[4:0];
         8'h54: begin
            if (b != 8'd0) begin
               m_dl   = 1'b1;
               m_addr = '0;
            end else begin
               m_dl = 1'b0;
            end
         end
         8'h55: begin
            if (m_dl) begin
               sb.push_back({m_addr, b});
               m_addr = m_addr + 1'b1;
            end
         end
         default: ;
      endcase
   endtask

   task automatic data_byte(input logic [7:0] c, input logic [7:0] b);
      model_byte(c, b);
      send_byte(b);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_dl"}, 32'(downloading), 32'(m_dl));
      chk({tag, "_idx"}, 32'(index), 32'(m_idx));
      chk({tag, "_addr"}, 32'(ioctl_addr), 32'(m_addr));
   endtask

   // Scoreboard: every strobe must match the oldest expected (addr,data) and be one cycle wide
   always @(negedge clk) begin
      if (ioctl_wr) begin
         if (prev_wr) begin
            checks++;
            errors++;
            $display("FAIL double_strobe: ioctl_wr high %0d cycles, expected 1", 2);
         end
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got addr=%0h data=%0h expected no strobe",
                     ioctl_addr, ioctl_data);
         end else begin
            chk("strobe_addr_data", 32'({ioctl_addr, ioctl_data}), 32'(sb.pop_front()));
         end
      end
      prev_wr = ioctl_wr;
   end

   initial begin
      vecs[0] = '{8'h53, 1, '{8'h05, 8'h00, 8'h00, 8'h00}, 1'b0, 5'd5,  4'd0};
      vecs[1] = '{8'h54, 1, '{8'h01, 8'h00, 8'h00, 8'h00}, 1'b1, 5'd5,  4'd0};
      vecs[2] = '{8'h55, 3, '{8'hA5, 8'h3C, 8'hFF, 8'h00}, 1'b1, 5'd5,  4'd3};
      vecs[3] = '{8'h54, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 5'd5,  4'd3};
      vecs[4] = '{8'h55, 2, '{8'h11, 8'h22, 8'h00, 8'h00}, 1'b0, 5'd5,  4'd3};
      vecs[5] = '{8'h53, 1, '{8'hE9, 8'h00, 8'h00, 8'h00}, 1'b0, 5'd9,  4'd3};
      vecs[6] = '{8'h54, 1, '{8'h80, 8'h00, 8'h00, 8'h00}, 1'b1, 5'd9,  4'd0};
      vecs[7] = '{8'h56, 2, '{8'h12, 8'h34, 8'h00, 8'h00}, 1'b1, 5'd9,  4'd0};
      vecs[8] = '{8'h53, 2, '{8'h03, 8'h0A, 8'h00, 8'h00}, 1'b1, 5'd10, 4'd0};

      rst = 1'b1; SPI_SCK = 1'b0; SPI_SS2 = 1'b1; SPI_DI = 1'b0;
      m_dl = 1'b0; m_idx = 5'd0; m_addr = '0;
      tick(3);
      chk("reset_wr", 32'(ioctl_wr), 32'd0);
      chk("reset_data", 32'(ioctl_data), 32'd0);
      rst = 1'b0;
      tick(100);
      check_state("idle");

      for (int v = 0; v < 9; v++) begin
         ss_low();
         send_byte(vecs[v].cmd);
         for (int k = 0; k < vecs[v].n; k++) data_byte(vecs[v].cmd, vecs[v].b[k]);
         ss_high();
         chk($sformatf("vec%0d_dl", v), 32'(downloading), 32'(vecs[v].exp_dl));
         chk($sformatf("vec%0d_idx", v), 32'(index), 32'(vecs[v].exp_idx));
         chk($sformatf("vec%0d_addr", v), 32'(ioctl_addr), 32'(vecs[v].exp_addr));
      end

      // Framing abort: a half byte is dropped, the next select starts with a command
      ss_low();
      send_byte(8'h55);
      data_byte(8'h55, 8'hA1);
      send_nibble(4'hB);
      ss_high();
      ss_low();
      send_byte(8'h53);
      data_byte(8'h53, 8'h07);
      ss_high();
      check_state("abort");

      // Address wrap at 2^AW
      ss_low();
      send_byte(8'h54);
      data_byte(8'h54, 8'h01);
      ss_high();
      ss_low();
      send_byte(8'h55);
      for (int k = 0; k < 17; k++) data_byte(8'h55, 8'(k * 7 + 1));
      ss_high();
      check_state("wrap");

      // Reset in the middle of the third data byte
      ss_low();
      send_byte(8'h55);
      data_byte(8'h55, 8'hC1);
      data_byte(8'h55, 8'hC2);
      send_nibble(4'hC);
      #3 rst = 1'b1;
      #1;
      m_dl = 1'b0; m_idx = 5'd0; m_addr = '0;
      check_state("rst_mid");
      chk("rst_mid_wr", 32'(ioctl_wr), 32'd0);
      chk("rst_mid_data", 32'(ioctl_data), 32'd0);
      tick(3);
      rst = 1'b0;
      half = 2;
      send_nibble(4'h3);
      ss_high();
      ss_low();
      send_byte(8'h55);
      data_byte(8'h55, 8'h44);
      ss_high();
      check_state("post_rst_ignored");
      ss_low();
      send_byte(8'h54);
      data_byte(8'h54, 8'h01);
      ss_high();
      ss_low();
      send_byte(8'h55);
      data_byte(8'h55, 8'h5A);
      data_byte(8'h55, 8'h6B);
      ss_high();
      check_state("post_rst_dl");

      tick(20);
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
